rvfi_dii_sequencer: RTL

Synthesizable DII-side front end for the rv32i core under RVFI-DII co-simulation. It accepts 8-byte DII command packets from a byte stream, buffers instruction packets in a FIFO, and hands instructions to the core one at a time. It tracks issued-but-unretired instructions and, on an end-of-trace command, drains the core, pulses the core reset and returns an end-of-trace response carrying the trace length. It is the instruction-source counterpart of the retirement-side RVFI packet producer.

---
 rtl/rvfi_dii_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/rvfi_dii_sequencer.sv
// RVFI-DII instruction-side sequencer: assembles 8-byte DII packets, buffers
// instructions, issues them to the core and runs the end-of-trace drain/reset/response handshake.
module rvfi_dii_sequencer #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned RST_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic [7:0]  rx_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   input  logic        retire_valid,
   output logic        core_rst_n,
   output logic        halt,
   output logic        eot_valid,
   input  logic        eot_ready,
   output logic [15:0] eot_count,
   output logic [7:0]  bad_cmd_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned OW = AW + 2;
   localparam int unsigned CW = $clog2(RST_CYCLES + 1);

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_rst_cnt;
   logic            r_resp_pending;

   logic [2:0]      r_byte_idx;
   logic [31:0]     r_insn;
   logic [7:0]      r_cmd;

   logic [31:0]     r_mem [FIFO_DEPTH];
   logic [AW:0]     r_wr_ptr;
   logic [AW:0]     r_rd_ptr;

   logic [OW-1:0]   r_outstanding;
   logic [15:0]     r_trace_count;
   logic [15:0]     r_eot_count;
   logic [7:0]      r_bad_cnt;

   logic            w_empty;
   logic            w_full;
   logic            w_run;
   logic            w_accept;
   logic            w_pkt_done;
   logic            w_push;
   logic            w_eot_cmd;
   logic            w_bad;
   logic            w_issue;
   logic            w_retire;
   logic            w_drain_done;
   logic            w_rst_exit;

   // FIFO status from wrap-bit pointers
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   assign w_run      = (r_state == S_RUN);
   assign rx_ready   = w_run && !((r_byte_idx == 3'd7) && (r_cmd == 8'd1) && w_full);
   assign w_accept   = rx_valid && rx_ready;
   assign w_pkt_done = w_accept && (r_byte_idx == 3'd7);
   assign w_push     = w_pkt_done && (r_cmd == 8'd1);
   assign w_eot_cmd  = w_pkt_done && (r_cmd == 8'd0);
   assign w_bad      = w_pkt_done && (r_cmd != 8'd0) && (r_cmd != 8'd1);

   assign instr_valid = !w_empty && ((r_state == S_RUN) || (r_state == S_DRAIN));
   assign instr       = instr_valid ? r_mem[r_rd_ptr[AW-1:0]] : 32'h0;
   assign halt        = !instr_valid;

   assign w_issue      = instr_valid && instr_ready;
   assign w_retire     = retire_valid && (r_outstanding != '0);
   assign w_drain_done = (r_state == S_DRAIN) && w_empty &&
                         (r_outstanding == '0) && !w_issue;
   assign w_rst_exit   = (r_state == S_RESET) && (r_rst_cnt == CW'(1));

   assign eot_count     = r_eot_count;
   assign bad_cmd_count = r_bad_cnt;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_RESET;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      core_rst_n  = 1'b1;
      eot_valid   = 1'b0;
      case (r_state)
         S_RESET: begin
            core_rst_n = 1'b0;
            if (w_rst_exit) w_state_nxt = r_resp_pending ? S_RESP : S_RUN;
         end
         S_RUN: begin
            if (w_eot_cmd) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_drain_done) w_state_nxt = S_RESET;
         end
         S_RESP: begin
            eot_valid = 1'b1;
            if (eot_ready) w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_RESET;
      endcase
   end

   // Core reset hold counter; reloaded on each drain completion
   always_ff @(posedge clk) begin
      if (rst || w_drain_done)
         r_rst_cnt <= CW'(RST_CYCLES);
      else if ((r_state == S_RESET) && (r_rst_cnt != '0))
         r_rst_cnt <= r_rst_cnt - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_resp_pending <= 1'b0;
      else if (w_eot_cmd)
         r_resp_pending <= 1'b1;
      else if ((r_state == S_RESP) && eot_ready)
         r_resp_pending <= 1'b0;
   end

   // Packet assembler: insn shifts in little-endian over bytes 0-3, cmd is byte 6
   always_ff @(posedge clk) begin
      if (rst) begin
         r_byte_idx <= 3'd0;
         r_insn     <= 32'h0;
         r_cmd      <= 8'h0;
      end else if (w_accept) begin
         r_byte_idx <= r_byte_idx + 3'd1;
         if (!r_byte_idx[2]) r_insn <= {rx_data, r_insn[31:8]};
         if (r_byte_idx == 3'd6) r_cmd <= rx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_insn;
   end

   always_ff @(posedge clk) begin
      if (rst || w_rst_exit) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push)  r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_issue) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // Issued-but-unretired tracking; a retire with nothing outstanding is dropped
   always_ff @(posedge clk) begin
      if (rst || w_rst_exit)
         r_outstanding <= '0;
      else if (w_issue && !w_retire)
         r_outstanding <= r_outstanding + OW'(1);
      else if (!w_issue && w_retire)
         r_outstanding <= r_outstanding - OW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_trace_count <= 16'h0;
      else if ((r_state == S_RESP) && eot_ready)
         r_trace_count <= 16'h0;
      else if (w_issue)
         r_trace_count <= r_trace_count + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_eot_count <= 16'h0;
      else if (w_rst_exit && r_resp_pending)
         r_eot_count <= r_trace_count;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_bad_cnt <= 8'h0;
      else if (w_bad && (r_bad_cnt != 8'hFF))
         r_bad_cnt <= r_bad_cnt + 8'd1;
   end

endmodule
